// File: rtl/ifetch_pc_arbiter_pkg.sv
// Shared fetch-front types and constants: thread index/bitmap types, PC scalar, fetch-group size.
// Pure declarations; no timing or flow control of its own.
package ifetch_pc_arbiter_pkg;

    localparam int IFETCH_NUM_THREADS = 4;
    localparam int IFETCH_FETCH_WIDTH = 1;
    localparam int IFETCH_GROUP_BYTES = 4 * IFETCH_FETCH_WIDTH;
    localparam int IFETCH_TIDX_W      = (IFETCH_NUM_THREADS > 1) ? $clog2(IFETCH_NUM_THREADS) : 1;

    typedef logic [31:0]                   scalar_t;
    typedef logic [IFETCH_TIDX_W-1:0]      local_thread_idx_t;
    typedef logic [IFETCH_NUM_THREADS-1:0] local_thread_bitmap_t;

    function automatic int tidx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ifetch_pc_arbiter_rr.sv
// Round-robin grant over NUM_REQUESTERS; combinational grant index, pointer moves only on advance.
// Latency 0 for the grant; a stalled consumer simply holds advance low and the order is preserved.
module ifetch_pc_arbiter_rr
    import ifetch_pc_arbiter_pkg::*;
#(
    parameter int  NUM_REQUESTERS = 4,
    localparam int IW             = tidx_width(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQUESTERS-1:0] req,
    input  logic                      advance,
    output logic [IW-1:0]             gnt_idx
);

    logic [IW-1:0] last;
    logic [IW-1:0] cand;

    // Scan from the farthest candidate back to last+1 so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_REQUESTERS; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % NUM_REQUESTERS);
            if (req[cand]) gnt_idx = cand;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= IW'(NUM_REQUESTERS - 1);
        end else if (advance) begin
            last <= gnt_idx;
        end
    end

endmodule

// File: rtl/ifetch_pc_arbiter.sv
// Per-thread fetch PC holder and round-robin issuer feeding icache tag/TLB; req_* 1 cycle after selection.
// fetch_block/halt_en/parked threads stall issue with PCs held; IFETCH_PERF_EN adds registered perf outputs.
module ifetch_pc_arbiter
    import ifetch_pc_arbiter_pkg::*;
#(
    parameter int      NUM_THREADS = IFETCH_NUM_THREADS,
    parameter int      FETCH_WIDTH = IFETCH_FETCH_WIDTH,
    parameter scalar_t RESET_PC    = 32'h0000_0000,
    localparam int     TIDX        = tidx_width(NUM_THREADS),
    localparam int     CW          = $clog2(FETCH_WIDTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_THREADS-1:0] fetch_en,
    input  logic                   fetch_block,
    input  logic                   halt_en,
    input  logic [TIDX-1:0]        halt_thread,
    input  logic                   miss_en,
    input  logic                   near_miss_en,
    input  logic [TIDX-1:0]        miss_thread_idx,
    input  logic [NUM_THREADS-1:0] wake_bitmap,
    input  logic                   rollback_en,
    input  logic [TIDX-1:0]        rollback_thread_idx,
    input  logic [31:0]            rollback_pc,
    output logic [31:0]            sel_pc,
    output logic                   req_valid,
    output logic [TIDX-1:0]        req_thread_idx,
    output logic [31:0]            req_pc,
    output logic [CW-1:0]          req_count,
    output logic [NUM_THREADS-1:0] wait_bitmap
`ifdef IFETCH_PERF_EN
    ,
    output logic                   perf_fetch_issued,
    output logic                   perf_icache_wait
`endif
);

    localparam int      GB       = 4 * FETCH_WIDTH;
    localparam scalar_t OFF_MASK = scalar_t'(GB - 1);
    localparam scalar_t GB_S     = scalar_t'(GB);

    logic [NUM_THREADS-1:0] can_fetch;
    logic [NUM_THREADS-1:0] miss_oh;
    logic [NUM_THREADS-1:0] wait_nxt;
    logic                   issue;
    logic                   miss_or_near;
    logic                   req_valid_nxt;
    logic [TIDX-1:0]        sel;
    scalar_t                next_pc [NUM_THREADS];
    scalar_t                sel_npc;
    scalar_t                grp_off;

    assign can_fetch    = fetch_en & ~wait_bitmap;
    assign issue        = (|can_fetch) & ~fetch_block & ~halt_en;
    assign miss_or_near = miss_en | near_miss_en;

    ifetch_pc_arbiter_rr #(
        .NUM_REQUESTERS (NUM_THREADS)
    ) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (can_fetch),
        .advance (issue),
        .gnt_idx (sel)
    );

    assign sel_pc  = next_pc[halt_en ? halt_thread : sel];
    assign sel_npc = next_pc[sel];
    assign grp_off = (sel_npc & OFF_MASK) >> 2;

    // A redirect to the thread being issued burns the slot rather than muxing the new PC in.
    assign req_valid_nxt = issue
                         & ~(miss_or_near && (miss_thread_idx == sel))
                         & ~(rollback_en && (rollback_thread_idx == sel));

    assign miss_oh  = miss_en ? (NUM_THREADS'(1) << miss_thread_idx) : '0;
    assign wait_nxt = (wait_bitmap | miss_oh) & ~wake_bitmap;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
        scalar_t npc_q;
        scalar_t lpc_q;
        logic    rb_hit;
        logic    miss_hit;
        logic    issue_hit;

        assign rb_hit    = rollback_en && (rollback_thread_idx == TIDX'(t));
        assign miss_hit  = miss_or_near && (miss_thread_idx == TIDX'(t));
        assign issue_hit = issue && (sel == TIDX'(t));

        // lpc_q keeps the last issued PC so a miss restores it exactly, whatever the group size.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                npc_q <= RESET_PC;
                lpc_q <= RESET_PC;
            end else if (rb_hit) begin
                npc_q <= rollback_pc;
            end else if (miss_hit) begin
                npc_q <= lpc_q;
            end else if (issue_hit) begin
                lpc_q <= npc_q;
                npc_q <= (npc_q & ~OFF_MASK) + GB_S;
            end
        end

        assign next_pc[t] = npc_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_valid      <= 1'b0;
            req_thread_idx <= '0;
            req_pc         <= RESET_PC;
            req_count      <= CW'(FETCH_WIDTH);
            wait_bitmap    <= '0;
        end else begin
            req_valid      <= req_valid_nxt;
            req_thread_idx <= sel;
            req_pc         <= sel_npc;
            req_count      <= CW'(scalar_t'(FETCH_WIDTH) - grp_off);
            wait_bitmap    <= wait_nxt;
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_issued <= 1'b0;
            perf_icache_wait  <= 1'b0;
        end else begin
            perf_fetch_issued <= req_valid_nxt;
            perf_icache_wait  <= |wait_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_pc_arbiter.sv
// Bench for ifetch_pc_arbiter: FETCH_WIDTH=1 and FETCH_WIDTH=4 instances share one stimulus stream.
// Hand-derived vector table, then randomized traffic against a thread-level reference model.
module tb_ifetch_pc_arbiter;
    import ifetch_pc_arbiter_pkg::*;

    localparam int NT = 4;
    localparam int NV = 41;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [3:0]  fetch_en;
    logic        fetch_block;
    logic        halt_en;
    logic [1:0]  halt_thread;
    logic        miss_en;
    logic        near_miss_en;
    logic [1:0]  miss_thread_idx;
    logic [3:0]  wake_bitmap;
    logic        rollback_en;
    logic [1:0]  rollback_thread_idx;
    logic [31:0] rollback_pc;

    logic [31:0] sel_pc_o    [2];
    logic        req_valid_o [2];
    logic [1:0]  req_tid_o   [2];
    logic [31:0] req_pc_o    [2];
    logic [3:0]  wait_o      [2];
    logic [0:0]  cnt1;
    logic [2:0]  cnt4;

    ifetch_pc_arbiter #(.NUM_THREADS(NT), .FETCH_WIDTH(1), .RESET_PC(32'h0)) u_fw1 (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .fetch_block(fetch_block),
        .halt_en(halt_en), .halt_thread(halt_thread), .miss_en(miss_en),
        .near_miss_en(near_miss_en), .miss_thread_idx(miss_thread_idx),
        .wake_bitmap(wake_bitmap), .rollback_en(rollback_en),
        .rollback_thread_idx(rollback_thread_idx), .rollback_pc(rollback_pc),
        .sel_pc(sel_pc_o[0]), .req_valid(req_valid_o[0]), .req_thread_idx(req_tid_o[0]),
        .req_pc(req_pc_o[0]), .req_count(cnt1), .wait_bitmap(wait_o[0])
    );

    ifetch_pc_arbiter #(.NUM_THREADS(NT), .FETCH_WIDTH(4), .RESET_PC(32'h0)) u_fw4 (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .fetch_block(fetch_block),
        .halt_en(halt_en), .halt_thread(halt_thread), .miss_en(miss_en),
        .near_miss_en(near_miss_en), .miss_thread_idx(miss_thread_idx),
        .wake_bitmap(wake_bitmap), .rollback_en(rollback_en),
        .rollback_thread_idx(rollback_thread_idx), .rollback_pc(rollback_pc),
        .sel_pc(sel_pc_o[1]), .req_valid(req_valid_o[1]), .req_thread_idx(req_tid_o[1]),
        .req_pc(req_pc_o[1]), .req_count(cnt4), .wait_bitmap(wait_o[1])
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: per-thread PCs for each instance, parked flags, last granted thread.
    logic [31:0] m_npc [2][NT];
    logic [31:0] m_lpc [2][NT];
    logic [3:0]  m_park;
    int          m_last;
    logic        e_vld;
    logic        e_chk;
    int          e_tid;
    logic [31:0] e_pc  [2];
    logic [31:0] e_cnt [2];

    typedef struct {
        logic [3:0]  en;
        logic        blk;
        logic        halt;
        logic        miss;
        logic [1:0]  midx;
        logic [3:0]  wake;
        logic        rb;
        logic [1:0]  ridx;
        logic [31:0] rpc;
        logic        e_vld;
        logic [1:0]  e_tid;
        logic [31:0] e_pc1;
        logic [31:0] e_pc4;
        logic [2:0]  e_cnt4;
        logic [3:0]  e_wait;
        logic        chk;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t v(int en, int blk, int halt, int miss, int midx, int wake, int rb,
                               int ridx, int rpc, int vld, int tid, int pc1, int pc4, int c4,
                               int wt, int chk);
        vec_t r;
        r.en = 4'(en);     r.blk = 1'(blk);    r.halt = 1'(halt);  r.miss = 1'(miss);
        r.midx = 2'(midx); r.wake = 4'(wake);  r.rb = 1'(rb);      r.ridx = 2'(ridx);
        r.rpc = 32'(rpc);  r.e_vld = 1'(vld);  r.e_tid = 2'(tid);  r.e_pc1 = 32'(pc1);
        r.e_pc4 = 32'(pc4); r.e_cnt4 = 3'(c4); r.e_wait = 4'(wt);  r.chk = 1'(chk);
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] t=%0t actual=%0h expected=%0h", name, k, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int k);
        return (k == 0) ? 32'(cnt1) : 32'(cnt4);
    endfunction

    function automatic int pick(input logic [3:0] can, input int last);
        for (int i = 1; i <= NT; i++) begin
            if (can[(last + i) % NT]) return (last + i) % NT;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int t = 0; t < NT; t++) begin
                m_npc[k][t] = 32'h0;
                m_lpc[k][t] = 32'h0;
            end
        m_park = 4'h0;
        m_last = NT - 1;
    endtask

    task automatic idle_inputs();
        fetch_en = 4'h0; fetch_block = 1'b0; halt_en = 1'b0; halt_thread = 2'd0;
        miss_en = 1'b0; near_miss_en = 1'b0; miss_thread_idx = 2'd0; wake_bitmap = 4'h0;
        rollback_en = 1'b0; rollback_thread_idx = 2'd0; rollback_pc = 32'h0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_valid", k, 32'(req_valid_o[k]), 32'h0);
            chk("rst_req_tid", k, 32'(req_tid_o[k]), 32'h0);
            chk("rst_req_pc", k, req_pc_o[k], 32'h0);
            chk("rst_req_count", k, cnt_of(k), (k == 0) ? 32'd1 : 32'd4);
            chk("rst_wait", k, 32'(wait_o[k]), 32'h0);
            chk("rst_sel_pc", k, sel_pc_o[k], 32'h0);
        end
    endtask

    // Inputs must already be applied (between a posedge and the next negedge).
    task automatic step();
        logic [3:0] can;
        logic       iss;
        int         s;
        @(negedge clk);
        can = fetch_en & ~m_park;
        s   = pick(can, m_last);
        iss = (can != 4'h0) && !fetch_block && !halt_en;
        for (int k = 0; k < 2; k++) begin
            if (halt_en) chk("sel_pc_halt", k, sel_pc_o[k], m_npc[k][halt_thread]);
            else if (can != 4'h0) chk("sel_pc", k, sel_pc_o[k], m_npc[k][s]);
        end
        e_chk = (can != 4'h0);
        e_vld = iss && !((miss_en || near_miss_en) && miss_thread_idx == s)
                    && !(rollback_en && rollback_thread_idx == s);
        if (e_chk) begin
            e_tid = s;
            for (int k = 0; k < 2; k++) begin
                e_pc[k]  = m_npc[k][s];
                e_cnt[k] = ((k == 0) ? 1 : 4) - (m_npc[k][s] % ((k == 0) ? 4 : 16)) / 4;
            end
        end
        for (int k = 0; k < 2; k++) begin
            int gb = (k == 0) ? 4 : 16;
            for (int t = 0; t < NT; t++) begin
                if (rollback_en && rollback_thread_idx == t) begin
                    m_npc[k][t] = rollback_pc;
                end else if ((miss_en || near_miss_en) && miss_thread_idx == t) begin
                    m_npc[k][t] = m_lpc[k][t];
                end else if (iss && s == t) begin
                    m_lpc[k][t] = m_npc[k][t];
                    m_npc[k][t] = m_npc[k][t] - (m_npc[k][t] % gb) + gb;
                end
            end
        end
        if (miss_en) m_park[miss_thread_idx] = 1'b1;
        m_park = m_park & ~wake_bitmap;
        if (iss) m_last = s;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("req_valid", k, 32'(req_valid_o[k]), 32'(e_vld));
            chk("wait_bitmap", k, 32'(wait_o[k]), 32'(m_park));
            if (e_chk) begin
                chk("req_tid", k, 32'(req_tid_o[k]), 32'(e_tid));
                chk("req_pc", k, req_pc_o[k], e_pc[k]);
                chk("req_count", k, cnt_of(k), e_cnt[k]);
            end
        end
    endtask

    task automatic random_inputs();
        fetch_en            = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
        fetch_block         = ($urandom_range(0, 9) == 0);
        halt_en             = ($urandom_range(0, 19) == 0);
        halt_thread         = 2'($urandom);
        miss_en             = ($urandom_range(0, 9) == 0);
        near_miss_en        = ($urandom_range(0, 14) == 0);
        miss_thread_idx     = 2'($urandom);
        wake_bitmap         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        rollback_en         = ($urandom_range(0, 11) == 0);
        rollback_thread_idx = 2'($urandom);
        rollback_pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                          : 32'($urandom_range(0, 1023)) << 2;
    endtask

    initial begin
        // en, blk, halt, miss, midx, wake, rb, ridx, rpc | vld, tid, pc1, pc4, cnt4, wait, chk
        tbl[0]  = v(15,0,0,0,0,0,0,0,0,      1,0,0,0,4,0,1);
        tbl[1]  = v(15,0,0,0,0,0,0,0,0,      1,1,0,0,4,0,1);
        tbl[2]  = v(15,0,0,0,0,0,0,0,0,      1,2,0,0,4,0,1);
        tbl[3]  = v(15,0,0,0,0,0,0,0,0,      1,3,0,0,4,0,1);
        tbl[4]  = v(15,0,0,0,0,0,0,0,0,      1,0,4,16,4,0,1);
        tbl[5]  = v(15,0,0,0,0,0,0,0,0,      1,1,4,16,4,0,1);
        tbl[6]  = v(15,0,0,0,0,0,0,0,0,      1,2,4,16,4,0,1);
        tbl[7]  = v(15,0,0,0,0,0,0,0,0,      1,3,4,16,4,0,1);
        tbl[8]  = v(15,1,0,0,0,0,0,0,0,      0,0,8,32,4,0,1);
        tbl[9]  = v(15,1,0,0,0,0,0,0,0,      0,0,8,32,4,0,1);
        tbl[10] = v(15,1,0,0,0,0,0,0,0,      0,0,8,32,4,0,1);
        tbl[11] = v(15,0,0,0,0,0,0,0,0,      1,0,8,32,4,0,1);
        tbl[12] = v(15,0,0,0,0,0,1,0,'h1008, 1,1,8,32,4,0,1);
        tbl[13] = v(15,0,0,0,0,0,0,0,0,      1,2,8,32,4,0,1);
        tbl[14] = v(15,0,0,0,0,0,0,0,0,      1,3,8,32,4,0,1);
        tbl[15] = v(15,0,0,0,0,0,0,0,0,      1,0,'h1008,'h1008,2,0,1);
        tbl[16] = v(15,0,0,0,0,0,0,0,0,      1,1,12,48,4,0,1);
        tbl[17] = v(15,0,0,0,0,0,0,0,0,      1,2,12,48,4,0,1);
        tbl[18] = v(15,0,0,0,0,0,0,0,0,      1,3,12,48,4,0,1);
        tbl[19] = v(15,0,0,0,0,0,0,0,0,      1,0,'h100c,'h1010,4,0,1);
        tbl[20] = v(15,0,0,1,1,0,0,0,0,      0,1,16,64,4,2,1);
        tbl[21] = v(15,0,0,0,0,0,0,0,0,      1,2,16,64,4,2,1);
        tbl[22] = v(15,0,0,0,0,0,0,0,0,      1,3,16,64,4,2,1);
        tbl[23] = v(15,0,0,0,0,0,0,0,0,      1,0,'h1010,'h1020,4,2,1);
        tbl[24] = v(15,0,0,0,0,0,0,0,0,      1,2,20,80,4,2,1);
        tbl[25] = v(15,0,0,0,0,2,0,0,0,      1,3,20,80,4,0,1);
        tbl[26] = v(15,0,0,0,0,0,0,0,0,      1,0,'h1014,'h1030,4,0,1);
        tbl[27] = v(15,0,0,0,0,0,0,0,0,      1,1,12,48,4,0,1);
        tbl[28] = v(15,0,0,1,2,4,0,0,0,      0,2,24,96,4,0,1);
        tbl[29] = v(15,0,0,0,0,0,0,0,0,      1,3,24,96,4,0,1);
        tbl[30] = v(15,0,0,0,0,0,0,0,0,      1,0,'h1018,'h1040,4,0,1);
        tbl[31] = v(15,0,0,0,0,0,0,0,0,      1,1,16,64,4,0,1);
        tbl[32] = v(15,0,0,0,0,0,0,0,0,      1,2,20,80,4,0,1);
        tbl[33] = v(15,0,0,0,0,0,1,3,'h2000, 0,3,28,112,4,0,1);
        tbl[34] = v(15,0,0,0,0,0,0,0,0,      1,0,'h101c,'h1050,4,0,1);
        tbl[35] = v(15,0,0,0,0,0,0,0,0,      1,1,20,80,4,0,1);
        tbl[36] = v(15,0,0,0,0,0,0,0,0,      1,2,24,96,4,0,1);
        tbl[37] = v(15,0,0,0,0,0,0,0,0,      1,3,'h2000,'h2000,4,0,1);
        tbl[38] = v(15,0,1,0,0,0,0,0,0,      0,0,'h1020,'h1060,4,0,1);
        tbl[39] = v(0,0,0,0,0,0,0,0,0,       0,0,0,0,4,0,0);
        tbl[40] = v(4,0,0,0,0,0,0,0,0,       1,2,28,112,4,0,1);

        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_reset_state();
        reset_n = 1'b1;
        sync();

        for (int i = 0; i < NV; i++) begin
            idle_inputs();
            fetch_en            = tbl[i].en;
            fetch_block         = tbl[i].blk;
            halt_en             = tbl[i].halt;
            halt_thread         = 2'd2;
            miss_en             = tbl[i].miss;
            miss_thread_idx     = tbl[i].midx;
            wake_bitmap         = tbl[i].wake;
            rollback_en         = tbl[i].rb;
            rollback_thread_idx = tbl[i].ridx;
            rollback_pc         = tbl[i].rpc;
            step();
            chk("tbl_valid", i, 32'(req_valid_o[0]), 32'(tbl[i].e_vld));
            chk("tbl_wait", i, 32'(wait_o[0]), 32'(tbl[i].e_wait));
            if (tbl[i].chk) begin
                chk("tbl_tid", i, 32'(req_tid_o[0]), 32'(tbl[i].e_tid));
                chk("tbl_pc_fw1", i, req_pc_o[0], tbl[i].e_pc1);
                chk("tbl_pc_fw4", i, req_pc_o[1], tbl[i].e_pc4);
                chk("tbl_cnt_fw4", i, 32'(cnt4), 32'(tbl[i].e_cnt4));
            end
        end

        for (int i = 0; i < 400; i++) begin
            random_inputs();
            step();
        end

        // Asynchronous reset in the middle of a cycle, no clock edge involved.
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state();
        idle_inputs();
        model_reset();
        #2;
        reset_n = 1'b1;
        sync();
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            fetch_en = 4'hF;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
